// File: rtl/ddr_axi_tester.sv
// AXI4 master that writes N 64-byte bursts of a known pattern, reads them back and counts errors.
// Define DDR_TESTER_LFSR_EN to use a seeded 64-bit Galois LFSR pattern instead of the address pattern.
package ddr_axi_tester_pkg;
    typedef struct packed {
        logic        aw_valid;
        logic [47:0] aw_addr;
        logic [7:0]  aw_len;
        logic [2:0]  aw_size;
        logic [1:0]  aw_burst;
        logic        aw_lock;
        logic [3:0]  aw_cache;
        logic [2:0]  aw_prot;
        logic [3:0]  aw_qos;
        logic [3:0]  aw_id;
        logic        w_valid;
        logic [63:0] w_data;
        logic [7:0]  w_strb;
        logic        w_last;
        logic        b_ready;
        logic        ar_valid;
        logic [47:0] ar_addr;
        logic [7:0]  ar_len;
        logic [2:0]  ar_size;
        logic [1:0]  ar_burst;
        logic        ar_lock;
        logic [3:0]  ar_cache;
        logic [2:0]  ar_prot;
        logic [3:0]  ar_qos;
        logic [3:0]  ar_id;
        logic        r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic        b_valid;
        logic [1:0]  b_resp;
        logic [3:0]  b_id;
        logic        ar_ready;
        logic        r_valid;
        logic [1:0]  r_resp;
        logic [63:0] r_data;
        logic        r_last;
        logic [3:0]  r_id;
    } axi4_master_in_type;
endpackage

module ddr_axi_tester
    import ddr_axi_tester_pkg::*;
#(
    parameter int async_reset = 1,
    parameter int BURST_BEATS = 8
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_start,
    input  logic [47:0]         i_base_addr,
    input  logic [15:0]         i_nbursts,
    input  logic [63:0]         i_seed,
    output axi4_master_out_type o_xmsto,
    input  axi4_master_in_type  i_xmsti,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_err_cnt
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_W    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_AR   = 3'd4;
    localparam logic [2:0] ST_R    = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    localparam logic [15:0] LAST_BEAT = 16'(BURST_BEATS - 1);

    typedef struct packed {
        logic [2:0]  state;
        logic [47:0] base;
        logic [15:0] nbursts;
        logic [47:0] addr;
        logic [15:0] remaining;
        logic [15:0] beat;
        logic [15:0] err_cnt;
        logic        done;
`ifdef DDR_TESTER_LFSR_EN
        logic [63:0] seed;
        logic [63:0] lfsr;
`endif
    } regs_t;

    localparam regs_t R_RESET = '0;

    regs_t       r;
    regs_t       rin;
    logic [63:0] pattern;
    logic [1:0]  errs;
    logic        last_err;
    logic        unused_ok;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

`ifdef DDR_TESTER_LFSR_EN
    // Galois form of x^64 + x^63 + x^61 + x^60 + 1, shifting towards bit 0.
    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
    endfunction

    assign pattern = lfsr_step(r.lfsr);
`else
    logic [31:0] beat_addr;

    assign beat_addr = r.addr[31:0] + {13'd0, r.beat, 3'b000};
    assign pattern   = {~beat_addr, beat_addr};
`endif

    assign unused_ok = ^{i_seed, i_xmsti.b_id, i_xmsti.r_id};
    assign last_err  = i_xmsti.r_last ? (r.beat != LAST_BEAT) : (r.beat >= LAST_BEAT);

    always_comb begin
        rin    = r;
        rin.done = 1'b0;
        errs   = 2'd0;
        case (r.state)
            ST_IDLE: if (i_start) begin
                rin.base      = {i_base_addr[47:6], 6'd0};
                rin.addr      = {i_base_addr[47:6], 6'd0};
                rin.nbursts   = i_nbursts;
                rin.remaining = i_nbursts;
                rin.beat      = 16'd0;
                rin.err_cnt   = 16'd0;
`ifdef DDR_TESTER_LFSR_EN
                rin.seed      = (i_seed == 64'd0) ? 64'd1 : i_seed;
                rin.lfsr      = (i_seed == 64'd0) ? 64'd1 : i_seed;
`endif
                rin.state     = (i_nbursts == 16'd0) ? ST_DONE : ST_AW;
            end
            ST_AW: if (i_xmsti.aw_ready) begin
                rin.state = ST_W;
                rin.beat  = 16'd0;
            end
            ST_W: if (i_xmsti.w_ready) begin
                rin.beat = r.beat + 16'd1;
`ifdef DDR_TESTER_LFSR_EN
                rin.lfsr = pattern;
`endif
                if (r.beat == LAST_BEAT) rin.state = ST_B;
            end
            ST_B: if (i_xmsti.b_valid) begin
                rin.err_cnt = sat_add(r.err_cnt, {1'b0, i_xmsti.b_resp != 2'b00});
                if (r.remaining > 16'd1) begin
                    rin.remaining = r.remaining - 16'd1;
                    rin.addr      = r.addr + 48'd64;
                    rin.state     = ST_AW;
                end else begin
                    // Read phase replays the whole region from the start.
                    rin.remaining = r.nbursts;
                    rin.addr      = r.base;
`ifdef DDR_TESTER_LFSR_EN
                    rin.lfsr      = r.seed;
`endif
                    rin.state     = ST_AR;
                end
            end
            ST_AR: if (i_xmsti.ar_ready) begin
                rin.state = ST_R;
                rin.beat  = 16'd0;
            end
            ST_R: if (i_xmsti.r_valid) begin
                errs = {1'b0, i_xmsti.r_resp != 2'b00} + {1'b0, i_xmsti.r_data != pattern}
                     + {1'b0, last_err};
                rin.err_cnt = sat_add(r.err_cnt, errs);
                rin.beat    = r.beat + 16'd1;
`ifdef DDR_TESTER_LFSR_EN
                rin.lfsr    = pattern;
`endif
                if (i_xmsti.r_last) begin
                    if (r.remaining > 16'd1) begin
                        rin.remaining = r.remaining - 16'd1;
                        rin.addr      = r.addr + 48'd64;
                        rin.state     = ST_AR;
                    end else begin
                        rin.state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                rin.state = ST_IDLE;
                rin.done  = 1'b1;
            end
            default: rin.state = ST_IDLE;
        endcase
    end

    generate
        if (async_reset != 0) begin : g_async
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) r <= R_RESET;
                else         r <= rin;
            end
        end else begin : g_sync
            always_ff @(posedge i_clk) begin
                if (!i_nrst) r <= R_RESET;
                else         r <= rin;
            end
        end
    endgenerate

    always_comb begin
        o_xmsto          = '0;
        o_xmsto.aw_valid = (r.state == ST_AW);
        o_xmsto.aw_addr  = r.addr;
        o_xmsto.aw_len   = 8'(BURST_BEATS - 1);
        o_xmsto.aw_size  = 3'd3;
        o_xmsto.aw_burst = 2'b01;
        o_xmsto.w_valid  = (r.state == ST_W);
        o_xmsto.w_data   = pattern;
        o_xmsto.w_strb   = 8'hFF;
        o_xmsto.w_last   = (r.beat == LAST_BEAT);
        o_xmsto.b_ready  = (r.state == ST_B);
        o_xmsto.ar_valid = (r.state == ST_AR);
        o_xmsto.ar_addr  = r.addr;
        o_xmsto.ar_len   = 8'(BURST_BEATS - 1);
        o_xmsto.ar_size  = 3'd3;
        o_xmsto.ar_burst = 2'b01;
        o_xmsto.r_ready  = (r.state == ST_R);
    end

    assign o_busy    = (r.state != ST_IDLE);
    assign o_done    = r.done;
    assign o_err_cnt = r.err_cnt;
endmodule

// File: tb/tb_ddr_axi_tester.sv
// Bench for ddr_axi_tester: table of scenarios run against a randomly stalling AXI memory slave,
// with expected addresses/data derived from the pattern rules and hand-computed error counts.
`timescale 1ns/1ps
module tb_ddr_axi_tester;
    import ddr_axi_tester_pkg::*;

    localparam int BB = 8;
`ifdef DDR_TESTER_LFSR_EN
    localparam bit LFSR_BUILD = 1'b1;
`else
    localparam bit LFSR_BUILD = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                nrst = 1'b0;
    logic                start = 1'b0;
    logic [47:0]         base_addr = '0;
    logic [15:0]         nbursts = '0;
    logic [63:0]         seed = '0;
    axi4_master_out_type xmsto;
    axi4_master_in_type  xmsti = '0;
    logic                busy;
    logic                done;
    logic [15:0]         err_cnt;

    ddr_axi_tester #(.async_reset(1), .BURST_BEATS(BB)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_base_addr(base_addr),
        .i_nbursts(nbursts), .i_seed(seed), .o_xmsto(xmsto), .i_xmsti(xmsti),
        .o_busy(busy), .o_done(done), .o_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [47:0] base;
        logic [15:0] n;
        logic [63:0] seed;
        int          stall;
        int          slverr_b;
        int          corr_b;
        int          corr_beat;
        int          rresp_b;
        int          rresp_beat;
        int          rlast_mode;
        int          rlast_b;
        bit          inject;
        bit          lfsr_ok;
        logic [15:0] exp_err;
    } vec_t;

    function automatic vec_t mk(logic [47:0] base, logic [15:0] n, logic [63:0] sd, int stall,
                                int slverr_b, int corr_b, int corr_beat, int rresp_b, int rresp_beat,
                                int rlast_mode, int rlast_b, bit inject, bit lfsr_ok, logic [15:0] exp_err);
        vec_t v;
        v.base = base; v.n = n; v.seed = sd; v.stall = stall; v.slverr_b = slverr_b;
        v.corr_b = corr_b; v.corr_beat = corr_beat; v.rresp_b = rresp_b; v.rresp_beat = rresp_beat;
        v.rlast_mode = rlast_mode; v.rlast_b = rlast_b; v.inject = inject; v.lfsr_ok = lfsr_ok;
        v.exp_err = exp_err;
        return v;
    endfunction

    // Reference model: what the master must emit, straight from the pattern rules.
    logic [47:0] exp_aw[$];
    logic [47:0] exp_ar[$];
    logic [63:0] exp_w[$];

    function automatic logic [63:0] addr_word(logic [47:0] a);
        return {~a[31:0], a[31:0]};
    endfunction

    function automatic logic [63:0] lfsr_next(logic [63:0] s);
        logic [63:0] taps;
        taps = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    task automatic build_model(input logic [47:0] base, input logic [15:0] n, input logic [63:0] sd);
        logic [47:0] a;
        logic [63:0] s;
        exp_aw.delete(); exp_ar.delete(); exp_w.delete();
        s = (sd == 64'd0) ? 64'd1 : sd;
        for (int k = 0; k < int'(n); k++) begin
            a = {base[47:6], 6'd0} + 48'(64 * k);
            exp_aw.push_back(a);
            exp_ar.push_back(a);
            for (int j = 0; j < BB; j++) begin
                s = lfsr_next(s);
                exp_w.push_back(LFSR_BUILD ? s : addr_word(a + 48'(8 * j)));
            end
        end
    endtask

    // Slave configuration and state.
    int stall_pct = 0, slverr_b = -1, corr_b = -1, corr_beat = -1, rresp_b = -1, rresp_beat = -1;
    int rlast_mode = 0, rlast_b = -1;
    logic [63:0] mem [logic [47:0]];
    logic [47:0] wr_addr, rd_addr, last_aw_addr;
    int wr_beat = 0, b_owed = 0, rd_beat = 0;
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, rd_burst = 0, valid_seen = 0;
    logic        rd_active = 1'b0;
    logic [63:0] first_w;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [47:0] p_aw_addr, p_ar_addr;
    logic [63:0] p_w_data;

    always @(negedge clk) begin
        logic [47:0] a;
        logic [63:0] d;
        if (!nrst) begin
            b_owed = 0; rd_active = 1'b0; wr_beat = 0; rd_beat = 0;
            p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
            xmsti = '0;
        end else begin
            if (p_aw) begin
                check("aw_hold_valid", xmsto.aw_valid, 1);
                check("aw_hold_addr", xmsto.aw_addr, p_aw_addr);
            end
            if (p_w) begin
                check("w_hold_valid", xmsto.w_valid, 1);
                check("w_hold_data", xmsto.w_data, p_w_data);
            end
            if (p_ar) begin
                check("ar_hold_valid", xmsto.ar_valid, 1);
                check("ar_hold_addr", xmsto.ar_addr, p_ar_addr);
            end
            if (xmsto.aw_valid || xmsto.w_valid || xmsto.ar_valid) valid_seen++;
            if (xmsto.aw_valid) check("aw_w_overlap", xmsto.w_valid, 0);

            xmsti.aw_ready = ($urandom_range(0, 99) >= stall_pct);
            xmsti.w_ready  = ($urandom_range(0, 99) >= stall_pct);
            xmsti.ar_ready = ($urandom_range(0, 99) >= stall_pct);
            xmsti.b_valid  = (b_owed > 0);
            xmsti.b_resp   = (b_n == slverr_b) ? 2'b10 : 2'b00;
            xmsti.r_valid  = rd_active && ($urandom_range(0, 99) >= stall_pct);
            a = rd_addr + 48'(8 * rd_beat);
            d = mem.exists(a) ? mem[a] : addr_word(a);
            if (rd_burst == corr_b && rd_beat == corr_beat) d = d ^ 64'h1;
            xmsti.r_data = d;
            xmsti.r_resp = (rd_burst == rresp_b && rd_beat == rresp_beat) ? 2'b10 : 2'b00;
            if (rd_burst == rlast_b && rlast_mode == 1)      xmsti.r_last = (rd_beat == 5);
            else if (rd_burst == rlast_b && rlast_mode == 2) xmsti.r_last = (rd_beat == BB + 1);
            else                                             xmsti.r_last = (rd_beat == BB - 1);

            if (xmsto.aw_valid && xmsti.aw_ready) begin
                if (exp_aw.size() == 0) begin
                    total++; bad++; $display("FAIL aw_extra: got %h expected none", xmsto.aw_addr);
                end else check("aw_addr", xmsto.aw_addr, exp_aw.pop_front());
                check("aw_attr", {xmsto.aw_len, xmsto.aw_size, xmsto.aw_burst, xmsto.aw_id, xmsto.aw_cache},
                      {8'(BB - 1), 3'd3, 2'b01, 4'd0, 4'd0});
                wr_addr = xmsto.aw_addr; last_aw_addr = xmsto.aw_addr; wr_beat = 0; aw_n++;
            end
            if (xmsto.w_valid && xmsti.w_ready) begin
                if (w_n == 0) first_w = xmsto.w_data;
                if (exp_w.size() == 0) begin
                    total++; bad++; $display("FAIL w_extra: got %h expected none", xmsto.w_data);
                end else check("w_data", xmsto.w_data, exp_w.pop_front());
                check("w_last_strb", {xmsto.w_last, xmsto.w_strb}, {wr_beat == BB - 1, 8'hFF});
                mem[wr_addr + 48'(8 * wr_beat)] = xmsto.w_data;
                if (wr_beat == BB - 1) b_owed++;
                wr_beat++; w_n++;
            end
            if (xmsti.b_valid && xmsto.b_ready) begin b_owed--; b_n++; end
            if (xmsti.r_valid && xmsto.r_ready) begin
                rd_beat++;
                if (xmsti.r_last) begin rd_active = 1'b0; rd_burst++; end
            end
            if (xmsto.ar_valid && xmsti.ar_ready) begin
                if (exp_ar.size() == 0) begin
                    total++; bad++; $display("FAIL ar_extra: got %h expected none", xmsto.ar_addr);
                end else check("ar_addr", xmsto.ar_addr, exp_ar.pop_front());
                rd_addr = xmsto.ar_addr; rd_beat = 0; rd_active = 1'b1; ar_n++;
            end
            p_aw = xmsto.aw_valid && !xmsti.aw_ready; p_aw_addr = xmsto.aw_addr;
            p_w  = xmsto.w_valid && !xmsti.w_ready;   p_w_data  = xmsto.w_data;
            p_ar = xmsto.ar_valid && !xmsti.ar_ready; p_ar_addr = xmsto.ar_addr;
        end
    end

    task automatic prep(input vec_t v);
        stall_pct = v.stall; slverr_b = v.slverr_b; corr_b = v.corr_b; corr_beat = v.corr_beat;
        rresp_b = v.rresp_b; rresp_beat = v.rresp_beat; rlast_mode = v.rlast_mode; rlast_b = v.rlast_b;
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; rd_burst = 0;
        build_model(v.base, v.n, v.seed);
        @(negedge clk);
        base_addr = v.base; nbursts = v.n; seed = v.seed; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit got = 1'b0;
        int busy_drop = 0;
        prep(v);
        for (int c = 0; c < 20000; c++) begin
            if (done) begin got = 1'b1; break; end
            if (!busy) busy_drop++;
            if (v.inject && c == 40) begin
                base_addr = 48'h0; nbursts = 16'd1; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("err_cnt", err_cnt, v.exp_err);
        check("busy_end", busy, 0);
        check("busy_held", busy_drop, 0);
        check("bursts", {16'(aw_n), 16'(b_n), 16'(ar_n), 16'(rd_burst)}, {v.n, v.n, v.n, v.n});
        check("w_beats", w_n, BB * int'(v.n));
        check("model_left", exp_aw.size() + exp_ar.size() + exp_w.size(), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int vs;
        bit hit;
        vecs[0] = mk(48'h0000_0000_0040, 16'd1, 64'd0, 0, -1, -1, -1, -1, -1, 0, -1, 0, 1, 16'd0);
        vecs[1] = mk(48'h0000_0000_0040, 16'd4, 64'd5, 0, 0, 2, 3, -1, -1, 0, -1, 0, 1, 16'd2);
        vecs[2] = mk(48'hFFFF_FFFF_FFC0, 16'd2, 64'd7, 0, -1, -1, -1, -1, -1, 0, -1, 0, 1, 16'd0);
        vecs[3] = mk(48'h1234_5678_9ABF, 16'd16, 64'hABCD, 50, -1, -1, -1, -1, -1, 0, -1, 1, 1, 16'd0);
        vecs[4] = mk(48'h0000_0010_0000, 16'd2, 64'd9, 20, -1, -1, -1, -1, -1, 1, 1, 0, 1, 16'd1);
        vecs[5] = mk(48'h0000_0020_0000, 16'd2, 64'd3, 20, -1, -1, -1, -1, -1, 2, 0, 0, 0, 16'd3);
        vecs[6] = mk(48'h0000_0030_0000, 16'd3, 64'd11, 30, -1, 1, 2, 1, 2, 0, -1, 0, 1, 16'd2);
        vecs[7] = mk({$urandom, $urandom}, 16'($urandom_range(1, 6)), {$urandom, $urandom},
                     int'($urandom_range(0, 60)), -1, -1, -1, -1, -1, 0, -1, 0, 1, 16'd0);

        #1;
        check("rst_valids", {xmsto.aw_valid, xmsto.w_valid, xmsto.ar_valid, xmsto.b_ready, xmsto.r_ready}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_cnt, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (LFSR_BUILD && !vecs[i].lfsr_ok) continue;
            run_vec(vecs[i]);
            if (i == 0) check("beat0_data", first_w, LFSR_BUILD ? 64'hD800_0000_0000_0000 : 64'hFFFF_FFBF_0000_0040);
            if (i == 2) check("wrap_addr", last_aw_addr, 48'h0);
        end

        // Zero bursts: busy for one cycle, done the next, no AXI traffic.
        vs = valid_seen;
        @(negedge clk);
        nbursts = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("n0_busy", busy, 1);
        check("n0_done_early", done, 0);
        @(negedge clk);
        check("n0_busy_off", busy, 0);
        check("n0_done", done, 1);
        @(negedge clk);
        check("n0_done_clear", done, 0);
        check("n0_no_valid", valid_seen - vs, 0);

        // Reset while writing burst 1, after burst 0 collected a SLVERR.
        prep(mk(48'h0000_0040_0000, 16'd4, 64'd1, 0, 0, -1, -1, -1, -1, 0, -1, 0, 1, 16'd1));
        hit = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (b_n >= 1 && xmsto.w_valid) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        check("rst_w_reached", hit, 1);
        check("pre_rst_err", err_cnt, 1);
        nrst = 1'b0;
        #1;
        check("mid_rst_valids", {xmsto.aw_valid, xmsto.w_valid, xmsto.ar_valid, xmsto.b_ready, xmsto.r_ready}, 0);
        check("mid_rst_status", {busy, done, err_cnt}, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        run_vec(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
